// File: rtl/at_delay_pipe_pkg.sv
// at_delay_pipe_pkg: shared attribute-path definitions (the at_defs set).
//   AT_WORD_W      default attribute word width
//   AT_DELAY_MAX   deepest supported delay line
//   AT_DATA_MAX_W  widest supported attribute word
//   at_even_parity even-parity helper over a zero-extended word
package at_delay_pipe_pkg;

  localparam int AT_WORD_W     = 64;
  localparam int AT_DELAY_MAX  = 8;
  localparam int AT_DATA_MAX_W = 128;

  // Even parity: the returned bit makes the total count of ones even.
  // Callers zero-extend narrower words, which leaves the result unchanged.
  function automatic logic at_even_parity(input logic [AT_DATA_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/at_delay_stage.sv
// at_delay_stage: one elastic delay stage (valid bit + data register).
// Ports:
//   gclk      clock, rising edge
//   reset_l   asynchronous active-low reset
//   flush     synchronous clear of the valid bit; data is kept
//   load      stage takes in_valid/in_data on this edge
//   in_valid  incoming valid (0 = bubble)
//   in_data   incoming word
//   valid     held valid bit
//   data      held word
// A bubble clears the valid bit but keeps the old data, so the data
// register only toggles when a real word arrives.
module at_delay_stage
  import at_delay_pipe_pkg::*;
#(
  parameter int W = AT_WORD_W
) (
  input  logic         gclk,
  input  logic         reset_l,
  input  logic         flush,
  input  logic         load,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         valid,
  output logic [W-1:0] data
);

  logic         v_r;
  logic [W-1:0] d_r;

  // Valid bit: flush wins, otherwise follow the incoming valid when loading.
  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      v_r <= 1'b0;
    end else if (flush) begin
      v_r <= 1'b0;
    end else if (load) begin
      v_r <= in_valid;
    end else begin
      v_r <= v_r;
    end
  end

  // Data register: captures only real words, never bubbles or flushed cycles.
  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      d_r <= '0;
    end else if (!flush && load && in_valid) begin
      d_r <= in_data;
    end else begin
      d_r <= d_r;
    end
  end

  assign valid = v_r;
  assign data  = d_r;

endmodule

// File: rtl/at_delay_pipe.sv
// at_delay_pipe: parametrised elastic delay line for attribute words.
// Optional feature macro: AT_DELAY_PARITY_EN (per-stage even parity with a
// sticky output-side parity error flag). Without it par_err is tied 0.
// Ports:
//   gclk      clock, rising edge
//   reset_l   asynchronous active-low reset
//   in_valid  upstream word present
//   in_data   upstream attribute word (WIDTH)
//   in_ready  word is accepted on this edge
//   stall     downstream cannot take out_data this cycle
//   flush     synchronous discard of every held word
//   out_valid out_data holds a valid word (straight from the last stage)
//   out_data  delayed attribute word (WIDTH)
//   count     number of valid stages (CNT_W)
//   par_err   sticky parity error
module at_delay_pipe
  import at_delay_pipe_pkg::*;
#(
  parameter int WIDTH = AT_WORD_W,
  parameter int DEPTH = 2,
  parameter int CNT_W = 4
) (
  input  logic             gclk,
  input  logic             reset_l,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count,
  output logic             par_err
);

  // Elaboration-time parameter checks.
  if (DEPTH < 1 || DEPTH > AT_DELAY_MAX) begin : g_bad_depth
    $error("at_delay_pipe: DEPTH must be 1..%0d", AT_DELAY_MAX);
  end
  if (WIDTH < 1 || WIDTH > AT_DATA_MAX_W) begin : g_bad_width
    $error("at_delay_pipe: WIDTH must be 1..%0d", AT_DATA_MAX_W);
  end
  if ((2 ** CNT_W) <= DEPTH) begin : g_bad_cnt
    $error("at_delay_pipe: CNT_W too narrow for DEPTH");
  end

`ifdef AT_DELAY_PARITY_EN
  localparam int SW = WIDTH + 1;  // parity rides in the MSB
`else
  localparam int SW = WIDTH;
`endif

  logic [DEPTH:0]   mv_s;
  logic [DEPTH-1:0] v_s;
  logic [SW-1:0]    d_s [DEPTH];
  logic [SW-1:0]    in_word_s;
  logic             accept_s;
  logic             leave_s;
  logic [CNT_W-1:0] cnt_r;

`ifdef AT_DELAY_PARITY_EN
  logic [AT_DATA_MAX_W-1:0] in_pad_s;

  // Attach even parity to the incoming word.
  always_comb begin
    in_pad_s              = '0;
    in_pad_s[WIDTH-1:0]   = in_data;
    in_word_s             = {at_even_parity(in_pad_s), in_data};
  end
`else
  assign in_word_s = in_data;
`endif

  // Move chain from the output end: a stage may advance if it is empty or
  // the stage after it advances, so bubbles collapse even while stalled.
  always_comb begin
    mv_s        = '0;
    mv_s[DEPTH] = ~stall;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      mv_s[k] = ~v_s[k] | mv_s[k+1];
    end
  end

  assign in_ready = mv_s[0] & ~flush;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic          st_vin_s;
    logic [SW-1:0] st_din_s;

    if (k == 0) begin : g_head
      assign st_vin_s = in_valid;
      assign st_din_s = in_word_s;
    end else begin : g_body
      assign st_vin_s = v_s[k-1];
      assign st_din_s = d_s[k-1];
    end

    at_delay_stage #(
      .W (SW)
    ) u_stage (
      .gclk     (gclk),
      .reset_l  (reset_l),
      .flush    (flush),
      .load     (mv_s[k]),
      .in_valid (st_vin_s),
      .in_data  (st_din_s),
      .valid    (v_s[k]),
      .data     (d_s[k])
    );
  end

  assign out_valid = v_s[DEPTH-1];
  assign out_data  = d_s[DEPTH-1][WIDTH-1:0];

  assign accept_s = in_valid & in_ready;
  assign leave_s  = out_valid & ~stall;

  // Occupancy: +1 on accept only, -1 on output only, cleared by flush.
  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      cnt_r <= '0;
    end else if (flush) begin
      cnt_r <= '0;
    end else if (accept_s && !leave_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else if (!accept_s && leave_s) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign count = cnt_r;

`ifdef AT_DELAY_PARITY_EN
  logic [AT_DATA_MAX_W-1:0] out_pad_s;
  logic                     par_bad_s;
  logic                     par_err_r;

  // Recompute parity of the presented word and compare with the stored bit.
  always_comb begin
    out_pad_s            = '0;
    out_pad_s[WIDTH-1:0] = d_s[DEPTH-1][WIDTH-1:0];
    par_bad_s            = v_s[DEPTH-1] &
                           (at_even_parity(out_pad_s) != d_s[DEPTH-1][WIDTH]);
  end

  // Sticky parity error, cleared only by reset or flush.
  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      par_err_r <= 1'b0;
    end else if (flush) begin
      par_err_r <= 1'b0;
    end else if (par_bad_s) begin
      par_err_r <= 1'b1;
    end else begin
      par_err_r <= par_err_r;
    end
  end

  assign par_err = par_err_r;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_at_delay_pipe.sv
// Scoreboard bench for at_delay_pipe (WIDTH=64, DEPTH=3).
module tb_at_delay_pipe;

  localparam int WIDTH = 64;
  localparam int DEPTH = 3;
  localparam int CNT_W = 4;

  logic             gclk;
  logic             reset_l;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             stall;
  logic             flush;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] count;
  logic             par_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH-1:0] exp_q [$];

  at_delay_pipe #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .gclk      (gclk),
    .reset_l   (reset_l),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .stall     (stall),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .count     (count),
    .par_err   (par_err)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge gclk);
    #1;
  endtask

  // Present a word and hold it until the pipe takes it (bounded wait).
  task automatic send(input logic [WIDTH-1:0] d);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 20 && !got; t++) begin
      if (in_ready) got = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("send_handshake", {63'd0, got}, 64'd1);
  endtask

  // Scoreboard: mid-cycle, pop/compare on consumption, push on accept.
  always @(negedge gclk) begin
    if (!reset_l || flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && !stall) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL out_unexpected: got %0h expected no word", out_data);
        end else begin
          logic [WIDTH-1:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            n_fail++;
            $display("FAIL out_data: got %0h expected %0h", out_data, e);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    reset_l  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    stall    = 1'b0;
    flush    = 1'b0;
    step();
    step();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data",  out_data, 64'd0);
    chk("rst_count",     {60'd0, count}, 64'd0);
    chk("rst_par_err",   {63'd0, par_err}, 64'd0);
    reset_l = 1'b1;
    step();

    // Streaming 1..5, first word visible after 3 edges.
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1;
      in_data  = 64'(i);
      step();
      if (i == 2) chk("lat_not_yet", {63'd0, out_valid}, 64'd0);
      if (i == 3) begin
        chk("lat_first_valid", {63'd0, out_valid}, 64'd1);
        chk("lat_first_data",  out_data, 64'h1);
      end
      if (i >= 3) chk("stream_count", {60'd0, count}, 64'd3);
    end
    in_valid = 1'b0;
    repeat (4) step();
    chk("stream_drained", {60'd0, count}, 64'd0);

    // Full stall then release.
    stall = 1'b1;
    send(64'hA);
    send(64'hB);
    send(64'hC);
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    chk("full_count",    {60'd0, count}, 64'd3);
    chk("full_head",     out_data, 64'hA);
    step();
    step();
    chk("full_hold_count", {60'd0, count}, 64'd3);
    stall = 1'b0;
    #1;
    chk("release_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (4) step();
    chk("full_drained", {60'd0, count}, 64'd0);

    // Bubble collapse under stall.
    in_valid = 1'b1; in_data = 64'h11; step();
    in_valid = 1'b0;                   step();
    in_valid = 1'b1; in_data = 64'h22; step();
    in_valid = 1'b0;
    stall    = 1'b1;
    step();
    chk("bub_count",    {60'd0, count}, 64'd2);
    chk("bub_in_ready", {63'd0, in_ready}, 64'd1);
    chk("bub_head",     out_data, 64'h11);
    in_valid = 1'b1; in_data = 64'h33;
    step();
    in_valid = 1'b0;
    chk("bub_full_count", {60'd0, count}, 64'd3);
    chk("bub_full_ready", {63'd0, in_ready}, 64'd0);
    stall = 1'b0;
    repeat (4) step();
    chk("bub_drained", {60'd0, count}, 64'd0);

    // Flush with two words held and a word presented.
    in_valid = 1'b1; in_data = 64'h44; step();
    in_data  = 64'h55; step();
    chk("pre_flush_count", {60'd0, count}, 64'd2);
    in_data = 64'h66;
    flush   = 1'b1;
    #1;
    chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
    step();
    flush = 1'b0;
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_count",     {60'd0, count}, 64'd0);
    in_data = 64'h77;
    step();
    in_valid = 1'b0;
    chk("post_flush_count", {60'd0, count}, 64'd1);
    repeat (3) step();
    chk("post_flush_drained", {60'd0, count}, 64'd0);

    // Asynchronous reset between edges.
    in_valid = 1'b1; in_data = 64'h88; step();
    in_data  = 64'h99; step();
    in_data  = 64'hAA; step();
    in_valid = 1'b0;
    chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    chk("pre_rst_data",  out_data, 64'h88);
    #2;
    reset_l = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_out_data",  out_data, 64'd0);
    chk("arst_count",     {60'd0, count}, 64'd0);
    step();
    reset_l = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("arst_no_stale", {63'd0, out_valid}, 64'd0);
    end

`ifdef AT_DELAY_PARITY_EN
    // Corrupt a held word in s[1] and watch the sticky flag.
    stall = 1'b1;
    in_valid = 1'b1; in_data = 64'hF0; step();
    in_valid = 1'b0; step();
    force dut.g_stage[1].u_stage.d_r[7] = 1'b0;
    step();
    release dut.g_stage[1].u_stage.d_r[7];
    chk("par_not_yet", {63'd0, par_err}, 64'd0);
    chk("par_bad_word", out_data, 64'h70);
    step();
    chk("par_set", {63'd0, par_err}, 64'd1);
    step();
    chk("par_sticky", {63'd0, par_err}, 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    stall = 1'b0;
    chk("par_flush_clear", {63'd0, par_err}, 64'd0);
`endif

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
